// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: state encoding, default protect hold-off and period split helpers
package pulse_gen_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POS  = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_NEG  = 3'd3;
  localparam logic [2:0] S_GAP2 = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;
  localparam logic [2:0] S_PROT = 3'd6;
  localparam int unsigned PROT_CYC_DEF = 100_000_000;
  function automatic int unsigned half_hi(input int unsigned p);
    return p < 2 ? 1 : (p + 1) / 2;
  endfunction
  function automatic int unsigned half_lo(input int unsigned p);
    return p < 2 ? 1 : p / 2;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter, saturates at zero
module phase_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic [W-1:0] load_val,
  input  logic         load,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/burst_pulse_gen.sv
// burst_pulse_gen: N-pulse uni/bipolar burst generator with protect hold-off
module burst_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int          PER_W    = 10,
  parameter int          NUM_W    = 6,
  parameter int          DEAD_W   = 4,
  parameter int unsigned PROT_CYC = PROT_CYC_DEF,
  parameter int          PROT_W   = 27
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [PER_W-1:0]  pulse_period,
  input  logic [NUM_W-1:0]  pulse_num,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic              bipolar,
  input  logic              burst_syn,
  input  logic              protect_en,
  output logic              pulse_p,
  output logic              pulse_n,
  output logic              busy,
  output logic              done,
  output logic              fault
);
  logic [2:0] state, nxt;
  logic [PER_W-1:0] lat_p, sel_p, h_m1, l_m1, d_m1, ld_val;
  logic [NUM_W-1:0] lat_n, sel_n, pcnt;
  logic [DEAD_W-1:0] lat_d, sel_d;
  logic lat_bi, sel_bi, idle, last, ld, ph_zero, pr_zero, pr_ld, done_nxt, pc_inc, pc_clr;
  assign idle = state == S_IDLE;
  // In IDLE the decision uses live inputs, since latching happens on the same edge
  assign sel_p = idle ? pulse_period : lat_p;
  assign sel_n = idle ? pulse_num : lat_n;
  assign sel_d = idle ? dead_time : lat_d;
  assign sel_bi = idle ? bipolar : lat_bi;
  assign h_m1 = PER_W'(half_hi(32'(sel_p)) - 1);
  assign l_m1 = PER_W'(half_lo(32'(sel_p)) - 1);
  assign d_m1 = PER_W'(sel_d) - PER_W'(1);
  assign last = pcnt == sel_n - NUM_W'(1);
  assign pr_ld = nxt == S_PROT && state != S_PROT;
  always_comb begin
    nxt = state;
    ld = 1'b0;
    ld_val = h_m1;
    done_nxt = 1'b0;
    pc_inc = 1'b0;
    pc_clr = 1'b0;
    if (protect_en && state != S_PROT) begin
      nxt = S_PROT;
      pc_clr = 1'b1;
    end else
      case (state)
        S_IDLE: if (burst_syn) begin
          pc_clr = 1'b1;
          nxt = sel_n == '0 ? S_WAIT : S_POS;
          done_nxt = sel_n == '0;
          ld = 1'b1;
        end
        S_POS: if (ph_zero) begin
          ld = 1'b1;
          if (sel_bi) begin
            nxt = sel_d != '0 ? S_GAP1 : S_NEG;
            ld_val = sel_d != '0 ? d_m1 : l_m1;
          end else begin
            nxt = last ? S_WAIT : S_GAP2;
            done_nxt = last;
            ld_val = l_m1;
          end
        end
        S_GAP1: if (ph_zero) begin
          nxt = S_NEG;
          ld = 1'b1;
          ld_val = l_m1;
        end
        S_NEG: if (ph_zero) begin
          ld = 1'b1;
          done_nxt = last;
          pc_inc = !last && sel_d == '0;
          nxt = last ? S_WAIT : sel_d != '0 ? S_GAP2 : S_POS;
          ld_val = sel_d != '0 ? d_m1 : h_m1;
        end
        S_GAP2: if (ph_zero) begin
          nxt = S_POS;
          ld = 1'b1;
          pc_inc = 1'b1;
        end
        S_WAIT: nxt = burst_syn ? S_WAIT : S_IDLE;
        S_PROT: nxt = pr_zero ? S_IDLE : S_PROT;
        default: nxt = S_IDLE;
      endcase
  end
  phase_timer #(.W(PER_W)) u_phase (
    .clk(clk), .RESET_N(RESET_N), .load_val(ld_val), .load(ld), .tick(1'b1), .zero(ph_zero)
  );
  phase_timer #(.W(PROT_W)) u_prot (
    .clk(clk), .RESET_N(RESET_N), .load_val(PROT_W'(PROT_CYC - 1)), .load(pr_ld),
    .tick(state == S_PROT), .zero(pr_zero)
  );
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      {lat_p, lat_n, lat_d, lat_bi, pcnt} <= '0;
      {pulse_p, pulse_n, busy, done, fault} <= '0;
    end else begin
      state <= nxt;
      if (idle && burst_syn) {lat_p, lat_n, lat_d, lat_bi} <= {pulse_period, pulse_num, dead_time, bipolar};
      pcnt <= pc_clr ? '0 : pc_inc ? pcnt + 1'b1 : pcnt;
      pulse_p <= nxt == S_POS;
      pulse_n <= nxt == S_NEG;
      busy <= nxt inside {S_POS, S_GAP1, S_NEG, S_GAP2};
      done <= done_nxt;
      fault <= nxt == S_PROT;
    end
endmodule
